// File: rtl/sgm_path_aggregator_8.sv
// Left-to-right SGM path cost aggregator for 8 disparities, one pixel per cycle.
// Define SGM_AGG_SATURATE_EN to clamp overflowing results instead of wrapping them.
module sgm_path_aggregator_8 #(
    parameter int COST_WIDTH = 6,
    parameter int ACC_WIDTH  = 8,
    parameter int P1         = 4,
    parameter int P2         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sol,
    input  logic [8*COST_WIDTH-1:0] in_costs,
    output logic                    out_valid,
    output logic                    out_sol,
    output logic [8*ACC_WIDTH-1:0]  out_costs
);

    localparam int EW = ACC_WIDTH + 2;
    localparam logic [EW-1:0] P1_E   = EW'(P1);
    localparam logic [EW-1:0] P2_E   = EW'(P2);
    localparam logic [EW-1:0] INF_E  = {EW{1'b1}};

    logic                   r_valid;
    logic                   r_sol;
    logic [8*ACC_WIDTH-1:0] r_costs;
    logic                   r_first_pending;

    logic [COST_WIDTH-1:0]  w_c      [8];
    logic [EW-1:0]          w_prev   [8];
    logic [EW-1:0]          w_left   [8];
    logic [EW-1:0]          w_right  [8];
    logic [EW-1:0]          w_cand   [8];
    logic [EW-1:0]          w_diff   [8];
    logic [ACC_WIDTH-1:0]   w_res    [8];
    logic [EW-1:0]          w_min_l1 [4];
    logic [EW-1:0]          w_min_l2 [2];
    logic [EW-1:0]          w_lmin;
    logic                   w_start;
    logic [8*ACC_WIDTH-1:0] w_next_costs;

    assign w_start = in_sol | r_first_pending;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_unpack
            assign w_c[g]    = in_costs[COST_WIDTH*g +: COST_WIDTH];
            assign w_prev[g] = EW'(r_costs[ACC_WIDTH*g +: ACC_WIDTH]);
        end

        // Min tree over L(p-1); strict '<' keeps the lower disparity on ties.
        for (g = 0; g < 4; g++) begin : g_min_l1
            assign w_min_l1[g] = (w_prev[2*g+1] < w_prev[2*g]) ? w_prev[2*g+1] : w_prev[2*g];
        end
        for (g = 0; g < 2; g++) begin : g_min_l2
            assign w_min_l2[g] = (w_min_l1[2*g+1] < w_min_l1[2*g]) ? w_min_l1[2*g+1] : w_min_l1[2*g];
        end
        assign w_lmin = (w_min_l2[1] < w_min_l2[0]) ? w_min_l2[1] : w_min_l2[0];

        for (g = 0; g < 8; g++) begin : g_lane
            logic [EW-1:0] w_m0;
            logic [EW-1:0] w_m1;

            // Edge disparities have no outer neighbour; an all-ones value never wins.
            if (g == 0) begin : g_no_left
                assign w_left[g] = INF_E;
            end else begin : g_has_left
                assign w_left[g] = w_prev[g-1] + P1_E;
            end
            if (g == 7) begin : g_no_right
                assign w_right[g] = INF_E;
            end else begin : g_has_right
                assign w_right[g] = w_prev[g+1] + P1_E;
            end

            assign w_m0      = (w_left[g] < w_prev[g]) ? w_left[g] : w_prev[g];
            assign w_m1      = (w_right[g] < (w_lmin + P2_E)) ? w_right[g] : (w_lmin + P2_E);
            assign w_cand[g] = (w_m1 < w_m0) ? w_m1 : w_m0;
            assign w_diff[g] = w_cand[g] - w_lmin;

`ifdef SGM_AGG_SATURATE_EN
            logic [EW-1:0] w_sum;
            assign w_sum    = EW'(w_c[g]) + w_diff[g];
            assign w_res[g] = (w_sum > EW'({ACC_WIDTH{1'b1}})) ? {ACC_WIDTH{1'b1}}
                                                                 : w_sum[ACC_WIDTH-1:0];
`else
            assign w_res[g] = ACC_WIDTH'(EW'(w_c[g]) + w_diff[g]);
`endif

            assign w_next_costs[ACC_WIDTH*g +: ACC_WIDTH] =
                w_start ? ACC_WIDTH'(w_c[g]) : w_res[g];
        end
    endgenerate

    // The output register doubles as the L(p-1) state, so it only moves on valid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_sol           <= 1'b0;
            r_costs         <= '0;
            r_first_pending <= 1'b1;
        end else begin
            r_valid <= in_valid;
            r_sol   <= in_valid & in_sol;
            if (in_valid) begin
                r_costs         <= w_next_costs;
                r_first_pending <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_sol   = r_sol;
    assign out_costs = r_costs;

endmodule

// File: doc/sgm_path_aggregator_8.md
Name: sgm_path_aggregator_8

Overview:
- Single-direction (left-to-right) SGM path cost aggregator for 8 disparities.
- Consumes a per-pixel matching cost vector C(p,0..7) from the cost stage and produces aggregated costs L(p,0..7).
- The output vector feeds the 8-input argmin stage directly.
- Recurrence: L(p,d) = C(p,d) + min(L(p-1,d), L(p-1,d-1)+P1, L(p-1,d+1)+P1, Lmin(p-1)+P2) - Lmin(p-1), where Lmin is the minimum over all 8 previous costs.

Parameters:
- COST_WIDTH, 6, bit width of each input matching cost.
- ACC_WIDTH, 8, bit width of each aggregated cost; must be >= COST_WIDTH.
- P1, 4, small penalty for a disparity change of +-1.
- P2, 16, large penalty for a disparity change of more than 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  in_costs valid this cycle.
- in_sol  in  1  start of line; qualified by in_valid.
- in_costs  in  8*COST_WIDTH  packed costs; disparity d occupies bits [COST_WIDTH*d +: COST_WIDTH].
- out_valid  out  1  out_costs valid.
- out_sol  out  1  registered copy of in_sol for the output pixel.
- out_costs  out  8*ACC_WIDTH  packed aggregated costs, same packing as in_costs.

Behaviour:
- Reset (asynchronous on rst_n low):
  - out_valid=0, out_sol=0, out_costs=0.
  - Internal first_pending flag set to 1.
- Latency: exactly 1 cycle, no backpressure. A pixel accepted at edge k appears on out_* after edge k with out_valid=1 for one cycle.
- Internal state: the out_costs register itself holds L(p-1) for the recurrence.
- Lmin(p-1):
  - Computed combinationally from the registered L(p-1) with a min tree.
  - On equal values the lower disparity index wins.
- Start of line: when in_valid=1 and (in_sol=1 or first_pending=1):
  - L(p,d) = C(p,d), zero-extended to ACC_WIDTH.
  - first_pending cleared.
  - out_sol = 1 only if in_sol was 1.
- Normal pixel (in_valid=1, in_sol=0, first_pending=0): apply the recurrence.
  - d=0 has no d-1 term; d=7 has no d+1 term.
  - The candidate minimum is evaluated in ACC_WIDTH+2 bits.
  - The subtraction of Lmin is never negative, because the candidate minimum is >= Lmin.
  - The sum C + (candidate - Lmin) is formed in ACC_WIDTH+2 bits, then reduced to ACC_WIDTH bits per the optional feature.
- in_valid=0:
  - out_costs and first_pending hold their values.
  - out_valid=0 and out_sol=0 the next cycle.
  - Gaps between pixels do not break the recurrence.
- in_sol with in_valid=0 is ignored.
- Reset asserted mid-line: the state is lost. The first valid pixel after reset is treated as start of line even if in_sol=0.
- Back-to-back in_sol pixels: each one restarts the line, so L = C every time.

Optional Feature:
- Macro: SGM_AGG_SATURATE_EN.
- Defined: a result exceeding 2^ACC_WIDTH-1 clamps to all-ones.
- Undefined: the result is truncated to its low ACC_WIDTH bits (wraps modulo 2^ACC_WIDTH). This is only safe when ACC_WIDTH >= clog2(2^COST_WIDTH + P2).
- Both builds produce identical results when there is no overflow.

Test Plan:
- Reset, then in_valid=1, in_sol=0, costs {d0..d7}={5,3,9,9,9,9,9,9}.
  -> next cycle out_valid=1, out_sol=0, out_costs={5,3,9,9,9,9,9,9} (first_pending forces start of line).
- Follow-up pixel in_valid=1, in_sol=0, all costs 0 (P1=4, P2=16).
  -> out_costs={2,0,4,6,6,6,6,6}.
- Three-cycle in_valid=0 gap, then costs all 0.
  -> during the gap out_valid=0 with out_costs held at {2,0,4,6,6,6,6,6}; after the gap out_costs={2,0,4,6,6,6,6,6}.
- Mid-line pixel with in_sol=1, costs {1,1,1,1,1,1,1,1}.
  -> out_costs={1,1,1,1,1,1,1,1}, out_sol=1.
- COST_WIDTH=6, ACC_WIDTH=6: start-of-line pixel {0,63,63,63,63,63,63,63}, then all costs 63.
  -> d5 raw result 79. With SGM_AGG_SATURATE_EN, L(5)=63; without it, L(5)=15.
- rst_n pulsed low asynchronously between pixels mid-line.
  -> out_valid and out_costs go to 0 immediately; the next valid pixel {7,6,5,4,3,2,1,0} outputs unchanged.
